// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// opcodes, FSM states and datapath mux/ALU selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating count of consecutive stalled memory cycles with a
// sticky timeout flag; the access itself is never abandoned.
module mc_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_state_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
    logic       stall;

    assign stall = mem_state_i && !mem_ready_i;

    always_comb begin
        cnt_d = 8'd0;
        if (stall) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
        // a ready cycle never increments, so it can never raise the flag
        to_d = to_q || (stall && (cnt_d == MAX_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = to_q;

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS core: sequences the shared
// memory, ALU and holding registers for lw/sw/R-type/beq/addi/j.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        illegal_op = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                pc_src    = PC_ALUOUT;
                state_d   = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // outputs are held quiet for the whole reset assertion
        if (!rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            alu_src_b  = SRCB_B;
            illegal_op = 1'b0;
        end
    end

    mc_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait (
        .clk        (clk),
        .rst        (rst),
        .mem_state_i(is_mem_state(state_q)),
        .mem_ready_i(mem_ready),
        .timeout_o  (mem_timeout)
    );

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a cycle-level reference
// model queues expected controls, a negedge monitor compares them.
module tb_multicycle_controller;

    localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
    localparam int EX = 6, AWB = 7, BR = 8, AE = 9, AIW = 10, JP = 11;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic mem_ready = 1'b0;
    logic pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic mem_timeout;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_dbg;

    multicycle_controller #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [21:0] act;
    assign act = {pc_write, branch, iord, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                  alu_op, pc_src, illegal_op, mem_timeout, state_dbg};

    typedef struct {
        logic       rdy;
        logic [5:0] op;
        logic [21:0] exp;
    } drv_t;

    drv_t        drv[$];
    logic [21:0] expq[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_cnt = 0;
    bit m_to = 0;

    task automatic check(input string name, input logic [21:0] a,
                         input logic [21:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, a, e);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};
    endfunction

    // expected control word for one cycle, straight from the state table
    function automatic logic [21:0] expv(input int st, input bit rdy,
                                         input logic [5:0] op, input bit to);
        logic pcw = 0, br = 0, ad = 0, mr = 0, mw = 0, irw = 0;
        logic rw = 0, rd = 0, m2r = 0, asa = 0, ill = 0;
        logic [1:0] asb = 0, aop = 0, ps = 0;
        logic [3:0] s4 = 4'(st);
        case (st)
            FE:  begin mr = 1; asb = 1; pcw = rdy; irw = rdy; end
            DE:  begin asb = 3; ill = !legal(op); end
            MA:  begin asa = 1; asb = 2; end
            MR:  begin mr = 1; ad = 1; end
            MWB: begin rw = 1; m2r = 1; end
            MW:  begin mw = 1; ad = 1; end
            EX:  begin asa = 1; aop = 2; end
            AWB: begin rw = 1; rd = 1; end
            BR:  begin asa = 1; aop = 1; br = 1; ps = 1; end
            AE:  begin asa = 1; asb = 2; end
            AIW: rw = 1;
            JP:  begin pcw = 1; ps = 2; end
            default: ;
        endcase
        return {pcw, br, ad, mr, mw, irw, rw, rd, m2r, asa, asb,
                aop, ps, ill, to, s4};
    endfunction

    task automatic emit(input int st, input bit rdy, input logic [5:0] op);
        drv_t d;
        d.rdy = rdy;
        d.op  = op;
        d.exp = expv(st, rdy, op, m_to);
        drv.push_back(d);
        if ((st == FE || st == MR || st == MW) && !rdy) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt == MAXW) m_to = 1;
        end else begin
            m_cnt = 0;
        end
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    task automatic gen(input logic [5:0] op, input int fst, input int mst);
        for (int i = 0; i < fst; i++) emit(FE, 1'b0, junk());
        emit(FE, 1'b1, junk());
        emit(DE, 1'($urandom), op);
        case (op)
            6'd35, 6'd43: begin
                emit(MA, 1'($urandom), op);
                for (int i = 0; i < mst; i++)
                    emit(op == 6'd35 ? MR : MW, 1'b0, junk());
                emit(op == 6'd35 ? MR : MW, 1'b1, junk());
                if (op == 6'd35) emit(MWB, 1'($urandom), junk());
            end
            6'd0: begin
                emit(EX, 1'($urandom), junk());
                emit(AWB, 1'($urandom), junk());
            end
            6'd4: emit(BR, 1'($urandom), junk());
            6'd8: begin
                emit(AE, 1'($urandom), junk());
                emit(AIW, 1'($urandom), junk());
            end
            6'd2: emit(JP, 1'($urandom), junk());
            default: ;
        endcase
    endtask

    task automatic play();
        drv_t d;
        while (drv.size() > 0) begin
            d = drv.pop_front();
            mem_ready = d.rdy;
            opcode = d.op;
            expq.push_back(d.exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst && expq.size() > 0) begin
                check($sformatf("cyc%0d", cyc), act, expq.pop_front());
                cyc++;
            end
        end
    end

    initial begin : stim
        logic [5:0] ops[7];
        ops = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43, 6'd63};
        #3;
        check("reset_hold", act, 22'd0);
        @(posedge clk);
        #1;
        check("reset_hold2", act, 22'd0);
        rst = 1'b1;

        gen(6'd0, 0, 0);
        gen(6'd35, 0, 3);
        gen(6'd4, 0, 0);
        gen(6'd2, 0, 0);
        gen(6'h3F, 0, 0);
        gen(6'd43, 0, 5);
        play();

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? junk()
                 : ops[$urandom_range(0, 6)];
            gen(op, $urandom_range(0, 2), $urandom_range(0, 5));
        end
        play();

        emit(FE, 1'b1, junk());
        emit(DE, 1'b1, 6'd43);
        emit(MA, 1'b1, 6'd43);
        for (int i = 0; i < 6; i++) emit(MW, 1'b0, junk());
        play();
        mem_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("reset_mid_stall", act, 22'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("reset_held", act, 22'd0);
        rst = 1'b1;
        m_cnt = 0;
        m_to = 0;
        gen(6'd43, 0, 0);
        gen(6'd35, 1, 2);
        play();

        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle variant of the 32-bit MIPS core. It replaces the single-cycle main decoder and sequences a shared datapath: one unified instruction/data memory, one ALU, and the IR, MDR, A, B and ALUOut holding registers. It decodes `lw`, `sw`, R-type, `beq`, `addi` and `j`. It stalls on a memory ready handshake and flags illegal opcodes and memory timeouts. The existing ALU decoder consumes `alu_op` unchanged.

## Interface
- `MAX_WAIT`, default 15: number of consecutive stalled memory cycles that sets `mem_timeout`. Legal range 1–255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 6: `IR[31:26]`, valid from DECODE onward.
- `mem_ready` in 1: memory has completed the current access; sampled in FETCH, MEMREAD and MEMWRITE only.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: PC load qualified by ALU zero. Combined externally as `pc_write | (branch & zero)`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1, `mem_write` out 1: memory request strobes.
- `ir_write` out 1: IR load.
- `reg_write` out 1, `reg_dst` out 1, `mem_to_reg` out 1: register file write controls.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B select; 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode funct.
- `pc_src` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `mem_timeout` out 1: sticky flag; cleared only by reset.
- `state_dbg` out 4: current state encoding.

## Operation
- The FSM has 12 states. Outputs are Moore outputs decoded from the state, except `ir_write` and `pc_write` in FETCH, which are additionally gated by `mem_ready`. Every signal not listed for a state is 0.
- **FETCH:** `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00, `ir_write`=`pc_write`=`mem_ready`. Goes to DECODE when `mem_ready`=1; otherwise stays.
- **DECODE:** `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precomputes the branch target). Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXECUTE
  - 000100 → BRANCH
  - 001000 → ADDIEXEC
  - 000010 → JUMP
  - any other opcode → FETCH with `illegal_op`=1 for that cycle.
- **MEMADR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next is MEMREAD if opcode is 100011, else MEMWRITE.
- **MEMREAD:** `mem_read`=1, `iord`=1. Goes to MEMWB on `mem_ready`; otherwise stays.
- **MEMWB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next is FETCH.
- **MEMWRITE:** `mem_write`=1, `iord`=1. Goes to FETCH on `mem_ready`; otherwise stays.
- **EXECUTE:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next is ALUWB.
- **ALUWB:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next is FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `branch`=1, `pc_src`=01. Next is FETCH.
- **ADDIEXEC:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next is ADDIWB.
- **ADDIWB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next is FETCH.
- **JUMP:** `pc_write`=1, `pc_src`=10. Next is FETCH.
- **Wait counter:**
  - 8-bit, saturating.
  - Increments in any memory state while `mem_ready`=0.
  - Clears on any cycle where `mem_ready`=1 or the state is not a memory state.
  - When the count equals `MAX_WAIT`, `mem_timeout` is set. The FSM keeps waiting; it never abandons an access.
- **Opcode sampling:** `opcode` is ignored outside DECODE and MEMADR.

## Timing
- **Latency with `mem_ready` tied to 1, measured from FETCH entry to the next FETCH entry:**
  - `beq`, `j`: 3 cycles
  - R-type, `addi`, `sw`: 4 cycles
  - `lw`: 5 cycles
  - illegal opcode: 2 cycles
- **Stalls:** each stalled cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. While stalled, `mem_read`/`mem_write` and the address select stay stable, and `ir_write`=`pc_write`=0.
- **`mem_ready` outside memory states** is a don't-care and has no effect.
- **Reset:**
  - While `rst`=0, every output is forced to 0 and `state_dbg`=FETCH encoding.
  - Wait counter is 0 and `mem_timeout`=0.
  - The first rising edge after `rst` rises executes FETCH.
- **Reset mid-instruction** (any state, including a stalled memory state): the FSM returns to FETCH asynchronously. The partial instruction is dropped, and no `reg_write` or `mem_write` occurs after `rst` falls.
- **Timeout coincident with `mem_ready`=1:** `mem_ready` wins. The counter clears and `mem_timeout` is not set in that cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`
  - the 4-bit state encoding: FETCH=0 … JUMP=11, in the order listed under Operation
  - `alu_op`, `alu_src_b` and `pc_src` encodings, shared with the ALU decoder and the datapath muxes
- Sub-module `mc_wait_timer` implements the saturating wait counter and the sticky timeout, with parameter `MAX_WAIT`.
- The rest of the block is a single always block for state and a combinational output decode.

## Test plan
- **R-type `add`, `mem_ready`=1:** states FETCH, DECODE, EXECUTE, ALUWB, FETCH. `reg_write`=1 and `reg_dst`=1 only in cycle 4; `alu_op`=10 in cycle 3.
- **`lw` with `mem_ready` low for 3 cycles in MEMREAD:** MEMREAD is held for 4 cycles with `iord`=1 and `mem_read`=1. MEMWB follows with `mem_to_reg`=1. Total 8 cycles.
- **`beq` then `j`:**
  - `beq`: `branch`=1, `alu_op`=01, `pc_src`=01 in cycle 3.
  - `j`: `pc_write`=1, `pc_src`=10 in cycle 3.
  - Each instruction takes 3 cycles.
- **Opcode 111111:** `illegal_op` pulses for exactly 1 cycle in DECODE, then FETCH. `reg_write` and `mem_write` stay 0 throughout.
- **`MAX_WAIT`=4, `mem_ready` held 0 in MEMWRITE:** `mem_timeout` rises after the 4th stalled cycle and stays 1 after `mem_ready` returns. `sw` completes normally.
- **`rst` pulled low while stalled in MEMWRITE:** all outputs are 0 immediately, `state_dbg`=0 and `mem_timeout`=0. After release, the first cycle is FETCH with `mem_read`=1.
